i2f_arbiter: RTL and testbench

// - Shares one fixed-to-float converter (i2f: valid pulse in; man/exp/sgn + valid pulse out) between N_REQ requesters.
// - Round-robin grant; one conversion in flight at a time.
// - Captures operands, issues a one-cycle start to the converter, waits for its done pulse, routes the result back to the winner.
// - Watchdog aborts a conversion that never completes.

---
 rtl/flog_pkg.sv | 21 ++
 rtl/rr_pick.sv | 33 +++
 rtl/i2f_arbiter.sv | 154 +++++++++++++++
 tb/tb_i2f_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flog_pkg.sv
// Shared types and defaults for the fixed-to-float datapath and its arbiter.
package flog_pkg;

  localparam int EXP_WIDTH   = 8;   // integer-part / exponent width
  localparam int MAN_WIDTH   = 7;   // fraction / mantissa width
  localparam int ARB_TIMEOUT = 64;  // converter worst case is ~28 cycles

  // Arbiter sequencing: accept -> start converter -> wait done -> respond
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Width of an index into n requesters; never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester after the last winner, wrapping.
module rr_pick
  import flog_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned k;

  // Scan last+1, last+2, ... so the previous winner is considered last
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int off = 1; off <= N; off++) begin
      k = (int'(last_i) + off) % N;
      if (!any_o && req_i[IW'(k)]) begin
        any_o           = 1'b1;
        gnt_o[IW'(k)]   = 1'b1;
        idx_o           = IW'(k);
      end
    end
  end

endmodule

// File: rtl/i2f_arbiter.sv
// Shares one fixed-to-float converter between N_REQ requesters.
// One conversion in flight; round-robin grant; watchdog aborts a
// conversion whose done pulse never arrives.
module i2f_arbiter
  import flog_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int EXP_WIDTH = flog_pkg::EXP_WIDTH,
  parameter int MAN_WIDTH = flog_pkg::MAN_WIDTH,
  parameter int TIMEOUT   = flog_pkg::ARB_TIMEOUT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    req_valid_i,
  input  logic [N_REQ-1:0][EXP_WIDTH-1:0]     req_int_i,
  input  logic [N_REQ-1:0][MAN_WIDTH-1:0]     req_frac_i,
  output logic [N_REQ-1:0]                    req_ready_o,
  output logic [N_REQ-1:0]                    resp_valid_o,
  output logic [MAN_WIDTH-1:0]                resp_man_o,
  output logic [EXP_WIDTH-1:0]                resp_exp_o,
  output logic                                resp_sgn_o,
  output logic                                resp_err_o,
  output logic                                busy_o,
  output logic                                cvt_valid_o,
  output logic [EXP_WIDTH-1:0]                cvt_int_o,
  output logic [MAN_WIDTH-1:0]                cvt_frac_o,
  input  logic                                cvt_valid_i,
  input  logic [MAN_WIDTH-1:0]                cvt_man_i,
  input  logic [EXP_WIDTH-1:0]                cvt_exp_i,
  input  logic                                cvt_sgn_i
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     last_q,  last_d;
  logic [IDX_W-1:0]     gidx_q,  gidx_d;
  logic [EXP_WIDTH-1:0] int_q,   int_d;
  logic [MAN_WIDTH-1:0] frac_q,  frac_d;
  logic [WD_W-1:0]      wd_q,    wd_d;
  logic [MAN_WIDTH-1:0] man_q,   man_d;
  logic [EXP_WIDTH-1:0] exp_q,   exp_d;
  logic                 sgn_q,   sgn_d;
  logic                 err_q,   err_d;

  logic [N_REQ-1:0]     pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  rr_pick #(.N(N_REQ), .IW(IDX_W)) u_pick (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Next-state and pulse outputs; everything holds unless a state acts
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gidx_d       = gidx_q;
    int_d        = int_q;
    frac_d       = frac_q;
    wd_d         = wd_q;
    man_d        = man_q;
    exp_d        = exp_q;
    sgn_d        = sgn_q;
    err_d        = err_q;
    req_ready_o  = '0;
    resp_valid_o = '0;
    cvt_valid_o  = 1'b0;
    case (state_q)
      IDLE: begin
        // Accept is combinational so the requester sees it this cycle;
        // suppressed under reset because the capture would be discarded.
        if (pick_any && !rst) begin
          req_ready_o = pick_gnt;
          gidx_d      = pick_idx;
          last_d      = pick_idx;
          int_d       = req_int_i[pick_idx];
          frac_d      = req_frac_i[pick_idx];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cvt_valid_o = 1'b1;
        wd_d        = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        // A done pulse on the expiry cycle still counts as a real result
        if (cvt_valid_i) begin
          man_d   = cvt_man_i;
          exp_d   = cvt_exp_i;
          sgn_d   = cvt_sgn_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          man_d   = '0;
          exp_d   = '0;
          sgn_d   = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        resp_valid_o[gidx_q] = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; pointer resets so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(N_REQ - 1);
      gidx_q  <= '0;
      int_q   <= '0;
      frac_q  <= '0;
      wd_q    <= '0;
      man_q   <= '0;
      exp_q   <= '0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
      wd_q    <= wd_d;
      man_q   <= man_d;
      exp_q   <= exp_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign cvt_int_o  = int_q;
  assign cvt_frac_o = frac_q;
  assign resp_man_o = man_q;
  assign resp_exp_o = exp_q;
  assign resp_sgn_o = sgn_q;
  assign resp_err_o = err_q;

endmodule

// File: tb/tb_i2f_arbiter.sv
// Bench for i2f_arbiter: converter model with programmable latency,
// table of single-request vectors, scoreboard of expected responses.
module tb_i2f_arbiter;

  localparam int N  = 4;
  localparam int EW = 8;
  localparam int MW = 7;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid_i;
  logic [N*EW-1:0] req_int_i;
  logic [N*MW-1:0] req_frac_i;
  logic [N-1:0]    req_ready_o, resp_valid_o;
  logic [MW-1:0]   resp_man_o;
  logic [EW-1:0]   resp_exp_o;
  logic            resp_sgn_o, resp_err_o, busy_o, cvt_valid_o;
  logic [EW-1:0]   cvt_int_o;
  logic [MW-1:0]   cvt_frac_o;
  logic            cvt_valid_i;
  logic [MW-1:0]   cvt_man_i;
  logic [EW-1:0]   cvt_exp_i;
  logic            cvt_sgn_i;

  always #5 clk = ~clk;

  i2f_arbiter #(.N_REQ(N), .EXP_WIDTH(EW), .MAN_WIDTH(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_int_i(req_int_i), .req_frac_i(req_frac_i),
    .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o),
    .resp_man_o(resp_man_o), .resp_exp_o(resp_exp_o),
    .resp_sgn_o(resp_sgn_o), .resp_err_o(resp_err_o), .busy_o(busy_o),
    .cvt_valid_o(cvt_valid_o), .cvt_int_o(cvt_int_o), .cvt_frac_o(cvt_frac_o),
    .cvt_valid_i(cvt_valid_i), .cvt_man_i(cvt_man_i),
    .cvt_exp_i(cvt_exp_i), .cvt_sgn_i(cvt_sgn_i)
  );

  // Operand sources per requester
  logic [EW-1:0] op_int [N];
  logic [MW-1:0] op_frac[N];
  always_comb begin
    req_int_i  = '0;
    req_frac_i = '0;
    for (int k = 0; k < N; k++) begin
      req_int_i[k*EW +: EW]  = op_int[k];
      req_frac_i[k*MW +: MW] = op_frac[k];
    end
  end

  // Converter model: done L cycles after the start is sampled; L=0 never
  int   lat = 1;
  int   cnt;
  logic mdl_done, spur;
  assign cvt_valid_i = mdl_done | spur;
  always @(posedge clk) begin
    if (rst) begin
      cnt      <= 0;
      mdl_done <= 1'b0;
    end else begin
      mdl_done <= 1'b0;
      if (cvt_valid_o) cnt <= lat;
      else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          mdl_done  <= 1'b1;
          cvt_man_i <= cvt_int_o[MW-1:0];
          cvt_exp_i <= EW'(cvt_frac_o);
          cvt_sgn_i <= cvt_int_o[EW-1];
        end
      end
    end
  end

  typedef struct {
    logic [N-1:0]  oh;
    logic [MW-1:0] man;
    logic [EW-1:0] ex;
    logic          sgn;
    logic          err;
    int            cyc;
  } exp_t;

  typedef struct {
    int            k;
    logic [EW-1:0] iv;
    logic [MW-1:0] fv;
    int            l;
    logic [MW-1:0] man;
    logic [EW-1:0] ex;
    logic          sgn;
    logic          err;
    int            dly;
  } vec_t;

  exp_t sbq[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0;
  bit   auto_push = 1'b0;
  int   st_cyc = -1;
  logic [EW-1:0] st_int;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic exp_t mk_exp(input int k, input int at, input int l);
    exp_t e;
    e.oh     = '0;
    e.oh[k]  = 1'b1;
    if (l > 0 && l <= TO - 1) begin
      e.man = op_int[k][MW-1:0];
      e.ex  = EW'(op_frac[k]);
      e.sgn = op_int[k][EW-1];
      e.err = 1'b0;
      e.cyc = at + 3 + l;
    end else begin
      e.man = '0;
      e.ex  = '0;
      e.sgn = 1'b0;
      e.err = 1'b1;
      e.cyc = at + 2 + TO;
    end
    return e;
  endfunction

  // Monitor: accepts, converter start timing, and response scoreboard
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      st_cyc = -1;
    end else begin
      if (req_ready_o != '0) begin
        chk("ready_onehot", 64'($countones(req_ready_o)), 64'd1);
        for (int k = 0; k < N; k++)
          if (req_ready_o[k]) begin
            if (auto_push) sbq.push_back(mk_exp(k, cyc, lat));
            st_cyc = cyc + 1;
            st_int = op_int[k];
          end
      end
      if (cvt_valid_o) begin
        chk("start_cycle", 64'(cyc), 64'(st_cyc));
        chk("start_int", 64'(cvt_int_o), 64'(st_int));
      end
      if (resp_valid_o != '0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid_o), 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("resp_onehot", 64'(resp_valid_o), 64'(e.oh));
          chk("resp_cycle",  64'(cyc),          64'(e.cyc));
          chk("resp_man",    64'(resp_man_o),   64'(e.man));
          chk("resp_exp",    64'(resp_exp_o),   64'(e.ex));
          chk("resp_sgn",    64'(resp_sgn_o),   64'(e.sgn));
          chk("resp_err",    64'(resp_err_o),   64'(e.err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(output int idx);
    idx = -1;
    for (int t = 0; t < 40 && idx < 0; t++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++)
        if (req_ready_o[k]) idx = k;
    end
    if (idx < 0) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
    sbq.delete();
    repeat (6) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_zero(input string tag);
    @(negedge clk);
    chk({tag, "_busy"},       64'(busy_o),       64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
    chk({tag, "_cvt_valid"},  64'(cvt_valid_o),  64'd0);
    chk({tag, "_resp_data"},  64'({resp_man_o, resp_exp_o, resp_sgn_o, resp_err_o}), 64'd0);
    chk({tag, "_cvt_data"},   64'({cvt_int_o, cvt_frac_o}), 64'd0);
  endtask

  vec_t tbl[7];
  int   idx;

  initial begin
    rst         = 1'b1;
    spur        = 1'b0;
    req_valid_i = '0;
    for (int k = 0; k < N; k++) begin
      op_int[k]  = '0;
      op_frac[k] = '0;
    end
    cvt_man_i = '0;
    cvt_exp_i = '0;
    cvt_sgn_i = 1'b0;

    //  k  int    frac   L   man    exp    sgn err dly
    tbl[0] = '{0, 8'h03, 7'h05, 10, 7'h03, 8'h05, 1'b0, 1'b0, 13};
    tbl[1] = '{1, 8'hA5, 7'h7F, 1,  7'h25, 8'h7F, 1'b1, 1'b0, 4};
    tbl[2] = '{2, 8'h80, 7'h00, 3,  7'h00, 8'h00, 1'b1, 1'b0, 6};
    tbl[3] = '{3, 8'h7F, 7'h2A, 15, 7'h7F, 8'h2A, 1'b0, 1'b0, 18}; // done on expiry
    tbl[4] = '{1, 8'h44, 7'h11, 0,  7'h00, 8'h00, 1'b0, 1'b1, 18}; // never done
    tbl[5] = '{0, 8'hFF, 7'h01, 19, 7'h00, 8'h00, 1'b0, 1'b1, 18}; // late done
    tbl[6] = '{2, 8'h12, 7'h34, 2,  7'h12, 8'h34, 1'b0, 1'b0, 5};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_zero("reset");
    tick();

    // All four requesting continuously: RR order 0,1,2,3,0
    auto_push = 1'b1;
    lat       = 5;
    for (int k = 0; k < N; k++) begin
      op_int[k]  = EW'(8'h10 + k * 8'h21);
      op_frac[k] = MW'(7'h03 + k * 7'h11);
    end
    req_valid_i = '1;
    for (int g = 0; g < 5; g++) begin
      wait_acc(idx);
      chk("rr_order", 64'(idx), 64'(g % N));
    end
    tick();
    req_valid_i = '0;
    drain();

    // Table of single requests, including timeout and expiry corners
    auto_push = 1'b0;
    for (int i = 0; i < 7; i++) begin
      lat              = tbl[i].l;
      op_int[tbl[i].k]  = tbl[i].iv;
      op_frac[tbl[i].k] = tbl[i].fv;
      req_valid_i[tbl[i].k] = 1'b1;
      wait_acc(idx);
      chk("tbl_grant", 64'(idx), 64'(tbl[i].k));
      if (idx >= 0) begin
        exp_t e;
        e.oh  = '0;
        e.oh[tbl[i].k] = 1'b1;
        e.man = tbl[i].man;
        e.ex  = tbl[i].ex;
        e.sgn = tbl[i].sgn;
        e.err = tbl[i].err;
        e.cyc = cyc + tbl[i].dly;
        sbq.push_back(e);
      end
      tick();
      req_valid_i = '0;
      drain();
      chk("data_hold", 64'({resp_man_o, resp_err_o}), 64'({tbl[i].man, tbl[i].err}));
    end

    // Reset mid-WAIT discards the conversion; pointer returns to N-1
    auto_push    = 1'b1;
    lat          = 10;
    op_int[2]    = 8'h5A;
    op_frac[2]   = 7'h3C;
    req_valid_i[2] = 1'b1;
    wait_acc(idx);
    chk("rst_grant", 64'(idx), 64'd2);
    tick();
    req_valid_i = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("midrst");
    repeat (20) tick();
    lat = 4;
    req_valid_i = 4'b1010;
    wait_acc(idx);
    chk("post_rst_first", 64'(idx), 64'd1);
    tick();
    req_valid_i[1] = 1'b0;
    wait_acc(idx);
    chk("post_rst_second", 64'(idx), 64'd3);
    tick();
    req_valid_i = '0;
    drain();

    // Stray converter pulses in IDLE and in RESP are ignored
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("spur_idle_busy", 64'(busy_o), 64'd0);
    tick();
    lat = 4;
    op_int[3]  = 8'h66;
    op_frac[3] = 7'h09;
    req_valid_i[3] = 1'b1;
    wait_acc(idx);
    chk("spur_grant", 64'(idx), 64'd3);
    tick();
    req_valid_i = '0;
    repeat (6) tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    @(negedge clk);
    chk("spur_resp_busy", 64'(busy_o), 64'd0);
    tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
